data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/store_lane_gen.sv | 43 ++++
 rtl/data_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and FSM state type for the data memory arbiter
package mem_arb_pkg;

  localparam int DEPTH_DEFAULT = 2048;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } dump_state_t;

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - store byte enables, lane replication and misalignment detect
module store_lane_gen
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_store,
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [3:0]        o_be,
  output logic [DATA_W-1:0] o_din,
  output logic              o_misalign
);

  // Decode size/offset into lane enables; misaligned stores get no enables at all
  always_comb begin
    o_be       = 4'b0000;
    o_din      = i_wdata;
    o_misalign = 1'b0;
    case (i_size)
      SZ_HALF: begin
        o_din = {(DATA_W/16){i_wdata[15:0]}};
        if (i_addr_lo[0]) o_misalign = 1'b1;
        else              o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_BYTE: begin
        o_din = {(DATA_W/8){i_wdata[7:0]}};
        o_be  = 4'b0001 << i_addr_lo;
      end
      default: begin
        // word, and the reserved encoding which behaves as a word
        if (i_addr_lo != 2'b00) o_misalign = 1'b1;
        else                    o_be = 4'b1111;
      end
    endcase
    if (!i_store) begin
      o_be       = 4'b0000;
      o_misalign = 1'b0;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - single-port data RAM shared by the MEM stage and a debug dump walker
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [1:0]        pipe_size,
  input  logic [31:0]       pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_rvalid,
  output logic              pipe_misalign,
  input  logic              dbg_start,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_valid,
  input  logic              dbg_ready,
  output logic              dbg_busy,
  output logic              dbg_done,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  dump_state_t       r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_dbg_data;
  logic              r_dbg_valid;
  logic              r_dbg_done;
  logic              r_pipe_rvalid;
  logic              r_pipe_misalign;

  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_din;
  logic              w_misalign;
  logic              w_pipe_go;
  logic              w_dump_rd;
  logic              w_unused_addr;

  store_lane_gen #(.DATA_W(DATA_W)) u_lane (
    .i_store    (pipe_we),
    .i_size     (pipe_size),
    .i_addr_lo  (pipe_addr[1:0]),
    .i_wdata    (pipe_wdata),
    .o_be       (w_be),
    .o_din      (w_din),
    .o_misalign (w_misalign)
  );

  // Bits above the RAM's address range do not select anything
  assign w_unused_addr = ^pipe_addr[31:ADDR_W+2];

  assign w_pipe_go = pipe_req & ~reset;
  assign w_dump_rd = (r_state == RD) & ~pipe_req & ~reset;

  // RAM port mux: the pipeline always wins, the dump only reads in otherwise idle RD cycles
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 4'b0000;
    ram_addr = '0;
    ram_din  = '0;
    if (w_pipe_go) begin
      ram_en   = 1'b1;
      ram_we   = w_be;
      ram_addr = pipe_addr[ADDR_W+1:2];
      ram_din  = w_din;
    end else if (w_dump_rd) begin
      ram_en   = 1'b1;
      ram_addr = r_cnt;
    end
  end

  // Load-return and misalign flags, one cycle behind the pipeline request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_rvalid   <= 1'b0;
      r_pipe_misalign <= 1'b0;
    end else begin
      r_pipe_rvalid   <= pipe_req & ~pipe_we;
      r_pipe_misalign <= pipe_req & w_misalign;
    end
  end

  // Dump walker: read word, capture it, hand it to the consumer, advance until the last word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dbg_data  <= '0;
      r_dbg_valid <= 1'b0;
      r_dbg_done  <= 1'b0;
    end else begin
      r_dbg_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (dbg_start) begin
            r_cnt   <= '0;
            r_state <= RD;
          end
        end
        RD: begin
          if (!pipe_req) r_state <= WAIT;
        end
        WAIT: begin
          r_dbg_data  <= ram_dout;
          r_dbg_valid <= 1'b1;
          r_state     <= SEND;
        end
        SEND: begin
          if (dbg_ready) begin
            r_dbg_valid <= 1'b0;
            if (r_cnt == LAST) begin
              r_dbg_done <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_cnt   <= r_cnt + ADDR_W'(1);
              r_state <= RD;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pipe_rdata    = r_pipe_rvalid ? ram_dout : '0;
  assign pipe_rvalid   = r_pipe_rvalid;
  assign pipe_misalign = r_pipe_misalign;
  assign dbg_data      = r_dbg_data;
  assign dbg_valid     = r_dbg_valid;
  assign dbg_done      = r_dbg_done;
  assign dbg_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_req;
  logic        pipe_we;
  logic [1:0]  pipe_size;
  logic [31:0] pipe_addr;
  logic [31:0] pipe_wdata;
  logic [31:0] pipe_rdata;
  logic        pipe_rvalid;
  logic        pipe_misalign;
  logic        dbg_start;
  logic [31:0] dbg_data;
  logic        dbg_valid;
  logic        dbg_ready;
  logic        dbg_busy;
  logic        dbg_done;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:2047];
  logic        pl_we;
  logic [10:0] pl_addr;
  logic [31:0] pl_data;

  int n_checks;
  int n_pass;

  logic [31:0] obs_words [0:7];
  int obs_n;
  int obs_done;
  int obs_busy;
  int obs_stall_bad;

  data_mem_arbiter #(.DATA_W(32), .ADDR_W(11), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_req      (pipe_req),
    .pipe_we       (pipe_we),
    .pipe_size     (pipe_size),
    .pipe_addr     (pipe_addr),
    .pipe_wdata    (pipe_wdata),
    .pipe_rdata    (pipe_rdata),
    .pipe_rvalid   (pipe_rvalid),
    .pipe_misalign (pipe_misalign),
    .dbg_start     (dbg_start),
    .dbg_data      (dbg_data),
    .dbg_valid     (dbg_valid),
    .dbg_ready     (dbg_ready),
    .dbg_busy      (dbg_busy),
    .dbg_done      (dbg_done),
    .ram_en        (ram_en),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous RAM with byte enables and a bench-side preload port
  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick;
    pl_we = 1'b0;
  endtask

  task automatic run_dump(input int stall_at, input int stall_len);
    obs_n = 0; obs_done = 0; obs_busy = 0; obs_stall_bad = 0;
    dbg_ready = 1'b1;
    dbg_start = 1'b1;
    tick;
    dbg_start = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc >= stall_at && cyc < stall_at + stall_len) begin
        pipe_req = 1'b1; pipe_we = 1'b0; pipe_size = 2'b00; pipe_addr = 32'h0000_0100;
      end else begin
        pipe_req = 1'b0;
      end
      #1;
      if (cyc >= stall_at && cyc < stall_at + stall_len &&
          (ram_addr !== 11'd64 || dbg_valid !== 1'b0 || dbg_busy !== 1'b1))
        obs_stall_bad++;
      if (dbg_busy === 1'b1) obs_busy++;
      if (dbg_done === 1'b1) obs_done++;
      if (dbg_valid === 1'b1 && dbg_ready === 1'b1) begin
        if (obs_n < 8) obs_words[obs_n] = dbg_data;
        obs_n++;
      end
      tick;
    end
    pipe_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pipe_req = 1'b1; pipe_we = 1'b1; pipe_size = 2'b00;
    pipe_addr = 32'h0; pipe_wdata = 32'hFFFF_FFFF;
    preload(11'd0, 32'h0000_0011);
    preload(11'd1, 32'h0000_0022);
    preload(11'd2, 32'h0000_0033);
    preload(11'd3, 32'h0000_0044);
    preload(11'd4, 32'hDEAD_BEEF);
    preload(11'd64, 32'h0000_0099);
    #1;
    n_checks++; if (ram_en !== 1'b0) $display("FAIL reset_ram_en: got %b want 0", ram_en); else n_pass++;
    n_checks++; if (ram_we !== 4'b0000) $display("FAIL reset_ram_we: got %b want 0000", ram_we); else n_pass++;
    n_checks++; if (dbg_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", dbg_busy); else n_pass++;
    n_checks++; if (dbg_valid !== 1'b0) $display("FAIL reset_dbg_valid: got %b want 0", dbg_valid); else n_pass++;
    n_checks++; if (dbg_done !== 1'b0) $display("FAIL reset_dbg_done: got %b want 0", dbg_done); else n_pass++;
    n_checks++; if (dbg_data !== 32'h0) $display("FAIL reset_dbg_data: got %h want 0", dbg_data); else n_pass++;
    n_checks++; if (pipe_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", pipe_rvalid); else n_pass++;
    n_checks++; if (pipe_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", pipe_rdata); else n_pass++;
    n_checks++; if (pipe_misalign !== 1'b0) $display("FAIL reset_misalign: got %b want 0", pipe_misalign); else n_pass++;
    pipe_req = 1'b0;
    pipe_we = 1'b0;
    reset = 1'b0;
    tick;
    n_checks++; if (ram_en !== 1'b0) $display("FAIL idle_ram_en: got %b want 0", ram_en); else n_pass++;
  endtask

  task automatic test_dump_basic;
    run_dump(-1, 0);
    n_checks++; if (obs_n !== 4) $display("FAIL dump_count: got %0d want 4", obs_n); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_words[i] !== 32'h11 * (i + 1)) $display("FAIL dump_word%0d: got %h want %h", i, obs_words[i], 32'h11 * (i + 1));
      else n_pass++;
    end
    n_checks++; if (obs_done !== 1) $display("FAIL dump_done: got %0d pulses want 1", obs_done); else n_pass++;
    n_checks++; if (obs_busy !== 13) $display("FAIL dump_busy: got %0d cycles want 13", obs_busy); else n_pass++;
  endtask

  task automatic test_dump_stall;
    run_dump(3, 5);
    n_checks++; if (obs_n !== 4) $display("FAIL stall_count: got %0d want 4", obs_n); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_words[i] !== 32'h11 * (i + 1)) $display("FAIL stall_word%0d: got %h want %h", i, obs_words[i], 32'h11 * (i + 1));
      else n_pass++;
    end
    n_checks++; if (obs_stall_bad !== 0) $display("FAIL stall_hold: got %0d bad cycles want 0", obs_stall_bad); else n_pass++;
    n_checks++; if (obs_done !== 1) $display("FAIL stall_done: got %0d pulses want 1", obs_done); else n_pass++;
    n_checks++; if (obs_busy !== 18) $display("FAIL stall_busy: got %0d cycles want 18", obs_busy); else n_pass++;
  endtask

  task automatic test_dump_reset;
    int unstable;
    int done_seen;
    unstable = 0;
    done_seen = 0;
    dbg_ready = 1'b0;
    dbg_start = 1'b1;
    tick;
    dbg_start = 1'b0;
    for (int i = 0; i < 10 && dbg_valid !== 1'b1; i++) tick;
    n_checks++; if (dbg_valid !== 1'b1) $display("FAIL abort_valid_wait: got %b want 1", dbg_valid); else n_pass++;
    n_checks++; if (dbg_data !== 32'h11) $display("FAIL abort_first_word: got %h want 00000011", dbg_data); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (dbg_valid !== 1'b1 || dbg_data !== 32'h11) unstable++;
    end
    n_checks++; if (unstable !== 0) $display("FAIL abort_hold: got %0d unstable cycles want 0", unstable); else n_pass++;
    reset = 1'b1;
    tick;
    if (dbg_done === 1'b1) done_seen++;
    n_checks++; if (dbg_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", dbg_valid); else n_pass++;
    n_checks++; if (dbg_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", dbg_busy); else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (dbg_done === 1'b1) done_seen++;
    end
    n_checks++; if (done_seen !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); else n_pass++;
    run_dump(-1, 0);
    n_checks++; if (obs_words[0] !== 32'h11) $display("FAIL restart_word0: got %h want 00000011", obs_words[0]); else n_pass++;
    n_checks++; if (obs_n !== 4) $display("FAIL restart_count: got %0d want 4", obs_n); else n_pass++;
    n_checks++; if (obs_done !== 1) $display("FAIL restart_done: got %0d want 1", obs_done); else n_pass++;
  endtask

  task automatic test_store_byte;
    pipe_req = 1'b1; pipe_we = 1'b1; pipe_size = 2'b10;
    pipe_addr = 32'h0000_0006; pipe_wdata = 32'h1234_56AB;
    #1;
    n_checks++; if (ram_en !== 1'b1) $display("FAIL byte_en: got %b want 1", ram_en); else n_pass++;
    n_checks++; if (ram_we !== 4'b0100) $display("FAIL byte_we: got %b want 0100", ram_we); else n_pass++;
    n_checks++; if (ram_addr !== 11'd1) $display("FAIL byte_addr: got %0d want 1", ram_addr); else n_pass++;
    n_checks++; if (ram_din !== 32'hABAB_ABAB) $display("FAIL byte_din: got %h want abababab", ram_din); else n_pass++;
    tick;
    pipe_req = 1'b0;
    #1;
    n_checks++; if (pipe_misalign !== 1'b0) $display("FAIL byte_misalign: got %b want 0", pipe_misalign); else n_pass++;
    n_checks++; if (mem[1] !== 32'h00AB_0022) $display("FAIL byte_ram: got %h want 00ab0022", mem[1]); else n_pass++;
  endtask

  task automatic test_store_half;
    pipe_req = 1'b1; pipe_we = 1'b1; pipe_size = 2'b01;
    pipe_addr = 32'h0000_0003; pipe_wdata = 32'h0000_1234;
    #1;
    n_checks++; if (ram_we !== 4'b0000) $display("FAIL half_mis_we: got %b want 0000", ram_we); else n_pass++;
    tick;
    pipe_req = 1'b0;
    #1;
    n_checks++; if (pipe_misalign !== 1'b1) $display("FAIL half_mis_flag: got %b want 1", pipe_misalign); else n_pass++;
    n_checks++; if (mem[0] !== 32'h0000_0011) $display("FAIL half_mis_ram: got %h want 00000011", mem[0]); else n_pass++;
    pipe_req = 1'b1; pipe_we = 1'b1; pipe_size = 2'b01;
    pipe_addr = 32'h0000_000A; pipe_wdata = 32'hFFFF_5678;
    #1;
    n_checks++; if (pipe_misalign !== 1'b1) $display("FAIL half_mis_pulse: got %b want 1", pipe_misalign); else n_pass++;
    n_checks++; if (ram_we !== 4'b1100) $display("FAIL half_hi_we: got %b want 1100", ram_we); else n_pass++;
    n_checks++; if (ram_din !== 32'h5678_5678) $display("FAIL half_hi_din: got %h want 56785678", ram_din); else n_pass++;
    tick;
    pipe_req = 1'b0;
    #1;
    n_checks++; if (pipe_misalign !== 1'b0) $display("FAIL half_hi_misalign: got %b want 0", pipe_misalign); else n_pass++;
    n_checks++; if (mem[2] !== 32'h5678_0033) $display("FAIL half_hi_ram: got %h want 56780033", mem[2]); else n_pass++;
  endtask

  task automatic test_store_word;
    pipe_req = 1'b1; pipe_we = 1'b1; pipe_size = 2'b00;
    pipe_addr = 32'h0000_0005; pipe_wdata = 32'h0BAD_0BAD;
    #1;
    n_checks++; if (ram_we !== 4'b0000) $display("FAIL word_mis_we: got %b want 0000", ram_we); else n_pass++;
    tick;
    pipe_size = 2'b11; pipe_addr = 32'h0000_000C; pipe_wdata = 32'hCAFE_F00D;
    #1;
    n_checks++; if (pipe_misalign !== 1'b1) $display("FAIL word_mis_flag: got %b want 1", pipe_misalign); else n_pass++;
    n_checks++; if (ram_we !== 4'b1111) $display("FAIL word_we: got %b want 1111", ram_we); else n_pass++;
    n_checks++; if (ram_din !== 32'hCAFE_F00D) $display("FAIL word_din: got %h want cafef00d", ram_din); else n_pass++;
    n_checks++; if (ram_addr !== 11'd3) $display("FAIL word_addr: got %0d want 3", ram_addr); else n_pass++;
    tick;
    pipe_req = 1'b0;
    #1;
    n_checks++; if (mem[3] !== 32'hCAFE_F00D) $display("FAIL word_ram: got %h want cafef00d", mem[3]); else n_pass++;
    n_checks++; if (mem[1] !== 32'h00AB_0022) $display("FAIL word_mis_ram: got %h want 00ab0022", mem[1]); else n_pass++;
  endtask

  task automatic test_load;
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_size = 2'b00;
    pipe_addr = 32'h0000_0010; pipe_wdata = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (ram_addr !== 11'd4) $display("FAIL load_addr: got %0d want 4", ram_addr); else n_pass++;
    n_checks++; if (ram_we !== 4'b0000) $display("FAIL load_we: got %b want 0000", ram_we); else n_pass++;
    n_checks++; if (ram_en !== 1'b1) $display("FAIL load_en: got %b want 1", ram_en); else n_pass++;
    tick;
    pipe_req = 1'b0;
    #1;
    n_checks++; if (pipe_rvalid !== 1'b1) $display("FAIL load_rvalid: got %b want 1", pipe_rvalid); else n_pass++;
    n_checks++; if (pipe_rdata !== 32'hDEAD_BEEF) $display("FAIL load_rdata: got %h want deadbeef", pipe_rdata); else n_pass++;
    n_checks++; if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL load_ram: got %h want deadbeef", mem[4]); else n_pass++;
    tick;
    n_checks++; if (pipe_rvalid !== 1'b0) $display("FAIL load_rvalid_clr: got %b want 0", pipe_rvalid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_size = 2'b00; pipe_addr = 32'h0000_0010;
    tick;
    pipe_addr = 32'h0000_0000;
    #1;
    n_checks++; if (pipe_rdata !== 32'hDEAD_BEEF) $display("FAIL b2b_first: got %h want deadbeef", pipe_rdata); else n_pass++;
    n_checks++; if (ram_addr !== 11'd0) $display("FAIL b2b_addr: got %0d want 0", ram_addr); else n_pass++;
    tick;
    pipe_req = 1'b0;
    #1;
    n_checks++; if (pipe_rvalid !== 1'b1) $display("FAIL b2b_rvalid: got %b want 1", pipe_rvalid); else n_pass++;
    n_checks++; if (pipe_rdata !== 32'h0000_0011) $display("FAIL b2b_second: got %h want 00000011", pipe_rdata); else n_pass++;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b1;
    pipe_req = 1'b0; pipe_we = 1'b0; pipe_size = 2'b00;
    pipe_addr = 32'h0; pipe_wdata = 32'h0;
    dbg_start = 1'b0; dbg_ready = 1'b0;
    pl_we = 1'b0; pl_addr = 11'd0; pl_data = 32'h0;
    tick;
    test_reset;
    test_dump_basic;
    test_dump_stall;
    test_dump_reset;
    test_store_byte;
    test_store_half;
    test_store_word;
    test_load;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
